// File: rtl/adc_serial_capture.sv
// adc_serial_capture: per START, pulses CNV, then clocks S bits MSB-first off SDO and strobes VALID with the new word.
// Optional sticky overrun flag OVR is built when ADC_CAP_OVR_EN is defined.
module adc_serial_capture #(
    parameter int S           = 12,
    parameter int CLK_DIV     = 2,
    parameter int CONV_CYCLES = 80
) (
    input  logic         CLK,
    input  logic         CLR,
    input  logic         START,
    input  logic         SDO,
    output logic         CNV,
    output logic         CS_N,
    output logic         SCK,
    output logic [S-1:0] DATA,
    output logic         VALID,
    output logic         BUSY
`ifdef ADC_CAP_OVR_EN
    ,
    output logic         OVR
`endif
);
    localparam int CW = $clog2(CONV_CYCLES + 1);
    localparam int DW = $clog2(CLK_DIV + 1);
    localparam int BW = $clog2(S + 1);

    typedef enum logic [1:0] {IDLE, CONV, SHIFT, DONE} state_t;

    state_t        state;
    logic [CW-1:0] conv_cnt;
    logic [DW-1:0] div_cnt;
    logic [BW-1:0] bit_cnt;
    logic [S-1:0]  shreg;

    // NOTE: all state uses non-blocking assignments so every register sees pre-edge values, whatever the statement order.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            state    <= IDLE;
            CNV      <= 1'b0;
            CS_N     <= 1'b1;
            SCK      <= 1'b0;
            DATA     <= '0;
            VALID    <= 1'b0;
            BUSY     <= 1'b0;
            conv_cnt <= '0;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            // NOTE: the shift register is cleared too, so a half-received word cannot leak into a later capture.
            shreg    <= '0;
`ifdef ADC_CAP_OVR_EN
            OVR      <= 1'b0;
`endif
        end else begin
`ifdef ADC_CAP_OVR_EN
            if (START && BUSY)
                OVR <= 1'b1;
`endif
            case (state)
                IDLE: begin
                    if (START) begin
                        state    <= CONV;
                        CNV      <= 1'b1;
                        BUSY     <= 1'b1;
                        conv_cnt <= '0;
                    end
                end
                CONV: begin
                    if (conv_cnt == CW'(CONV_CYCLES - 1)) begin
                        state   <= SHIFT;
                        CNV     <= 1'b0;
                        CS_N    <= 1'b0;
                        SCK     <= 1'b0;
                        div_cnt <= '0;
                        bit_cnt <= '0;
                        shreg   <= '0;
                    end else begin
                        conv_cnt <= conv_cnt + CW'(1);
                    end
                end
                SHIFT: begin
                    // Each half-phase lasts CLK_DIV cycles; SDO is taken on the edge that raises SCK.
                    if (div_cnt == DW'(CLK_DIV - 1)) begin
                        div_cnt <= '0;
                        if (!SCK) begin
                            SCK   <= 1'b1;
                            shreg <= {shreg[S-2:0], SDO};
                        end else if (bit_cnt == BW'(S - 1)) begin
                            state <= DONE;
                            SCK   <= 1'b0;
                            CS_N  <= 1'b1;
                            DATA  <= shreg;
                            VALID <= 1'b1;
                        end else begin
                            SCK     <= 1'b0;
                            bit_cnt <= bit_cnt + BW'(1);
                        end
                    end else begin
                        div_cnt <= div_cnt + DW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    VALID <= 1'b0;
                    BUSY  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_adc_serial_capture.sv
// Self-checking bench for adc_serial_capture: default instance (S=12, CLK_DIV=2, CONV_CYCLES=80)
// and a fast instance (S=8, CLK_DIV=1, CONV_CYCLES=1), each fed by a behavioural SPI ADC model.
module tb_adc_serial_capture;
    localparam int SA = 12, DA = 2, CA = 80;
    localparam int SB = 8,  DB = 1, CB = 1;
    localparam int LAT_A = CA + 2 * DA * SA + 1;
    localparam int LAT_B = CB + 2 * DB * SB + 1;

    logic CLK = 1'b0;
    logic CLR;
    logic start_a, sdo_a, cnv_a, cs_n_a, sck_a, valid_a, busy_a;
    logic start_b, sdo_b, cnv_b, cs_n_b, sck_b, valid_b, busy_b;
    logic [SA-1:0] data_a;
    logic [SB-1:0] data_b;
`ifdef ADC_CAP_OVR_EN
    logic ovr_a, ovr_b;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    adc_serial_capture #(.S(SA), .CLK_DIV(DA), .CONV_CYCLES(CA)) dut_a (
        .CLK(CLK), .CLR(CLR), .START(start_a), .SDO(sdo_a),
        .CNV(cnv_a), .CS_N(cs_n_a), .SCK(sck_a), .DATA(data_a),
        .VALID(valid_a), .BUSY(busy_a)
`ifdef ADC_CAP_OVR_EN
        , .OVR(ovr_a)
`endif
    );

    adc_serial_capture #(.S(SB), .CLK_DIV(DB), .CONV_CYCLES(CB)) dut_b (
        .CLK(CLK), .CLR(CLR), .START(start_b), .SDO(sdo_b),
        .CNV(cnv_b), .CS_N(cs_n_b), .SCK(sck_b), .DATA(data_b),
        .VALID(valid_b), .BUSY(busy_b)
`ifdef ADC_CAP_OVR_EN
        , .OVR(ovr_b)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ADC models: present the next MSB-first bit of the queued word; the bit index advances after each SCK rise.
    logic [SA-1:0] qa[$];
    logic [SB-1:0] qb[$];
    int   idx_a = 0, idx_b = 0;
    logic prev_sck_a = 1'b0, prev_sck_b = 1'b0;

    always @(negedge CLK) begin
        logic [SA-1:0] w;
        if (cs_n_a === 1'b1) idx_a = 0;
        else if (sck_a === 1'b1 && !prev_sck_a) idx_a++;
        prev_sck_a = (sck_a === 1'b1);
        w = (qa.size() > 0) ? qa[0] : '0;
        sdo_a = (idx_a < SA) ? w[SA-1-idx_a] : 1'b0;
        if (valid_a === 1'b1 && qa.size() > 0) void'(qa.pop_front());
    end

    always @(negedge CLK) begin
        logic [SB-1:0] w;
        if (cs_n_b === 1'b1) idx_b = 0;
        else if (sck_b === 1'b1 && !prev_sck_b) idx_b++;
        prev_sck_b = (sck_b === 1'b1);
        w = (qb.size() > 0) ? qb[0] : '0;
        sdo_b = (idx_b < SB) ? w[SB-1-idx_b] : 1'b0;
        if (valid_b === 1'b1 && qb.size() > 0) void'(qb.pop_front());
    end

    task automatic pulse_clr();
        @(negedge CLK); CLR = 1'b1;
        @(negedge CLK); CLR = 1'b0;
    endtask

    // One capture on instance A; optional extra START pulses during SHIFT and in the DONE cycle.
    task automatic cap_a(input logic [SA-1:0] word, input logic [SA-1:0] prev, input bit pulse_busy);
        int first_valid, n_valid, cnv_first, cnv_last, n_cnv, n_rise, n_csl, early_chg, busy_bad;
        logic ps;
        logic [SA-1:0] got;
        first_valid = -1; n_valid = 0; cnv_first = -1; cnv_last = -1; n_cnv = 0;
        n_rise = 0; n_csl = 0; early_chg = 0; busy_bad = 0; ps = 1'b0; got = '0;
        qa.push_back(word);
        @(negedge CLK); start_a = 1'b1;
        @(posedge CLK);
        for (int n = 1; n <= LAT_A + 40; n++) begin
            @(negedge CLK);
            if (cnv_a) begin n_cnv++; if (cnv_first < 0) cnv_first = n; cnv_last = n; end
            if (!cs_n_a) n_csl++;
            if (sck_a && !ps) n_rise++;
            ps = sck_a;
            if (valid_a) begin
                n_valid++;
                if (first_valid < 0) begin first_valid = n; got = data_a; end
            end
            if (n < LAT_A && data_a !== prev) early_chg++;
            if (busy_a !== (n <= LAT_A)) busy_bad++;
            start_a = pulse_busy && (n == CA + 10 || n == LAT_A);
        end
        check("a_valid_cycle", first_valid, LAT_A);
        check("a_valid_count", n_valid, 1);
        check("a_data_at_valid", got, word);
        check("a_data_hold", data_a, word);
        check("a_cnv_cycles", n_cnv, CA);
        check("a_cnv_first", cnv_first, 1);
        check("a_cnv_last", cnv_last, CA);
        check("a_sck_rises", n_rise, SA);
        check("a_csn_low_cycles", n_csl, 2 * DA * SA);
        check("a_data_early_change", early_chg, 0);
        check("a_busy_pattern", busy_bad, 0);
    endtask

    // START held high across two conversions: VALIDs 130 apart, one idle cycle between.
    task automatic b2b_a(input logic [SA-1:0] w1, input logic [SA-1:0] w2);
        int v[2];
        logic [SA-1:0] d[2];
        int n_valid, busy_low;
        n_valid = 0; busy_low = 0; v[0] = -1; v[1] = -1; d[0] = '0; d[1] = '0;
        qa.push_back(w1);
        qa.push_back(w2);
        @(negedge CLK); start_a = 1'b1;
        @(posedge CLK);
        for (int n = 1; n <= 2 * LAT_A + 41; n++) begin
            @(negedge CLK);
            if (valid_a) begin
                if (n_valid < 2) begin v[n_valid] = n; d[n_valid] = data_a; end
                n_valid++;
            end
            if (n_valid == 1 && !valid_a && !busy_a) busy_low++;
            start_a = (n <= LAT_A + 1);
        end
        check("b2b_valid_count", n_valid, 2);
        check("b2b_first_valid", v[0], LAT_A);
        check("b2b_spacing", v[1] - v[0], LAT_A + 1);
        check("b2b_data_1", d[0], w1);
        check("b2b_data_2", d[1], w2);
        check("b2b_busy_low_cycles", busy_low, 1);
    endtask

    task automatic reset_mid_a(input logic [SA-1:0] word);
        int n_valid;
        n_valid = 0;
        qa.push_back(word);
        @(negedge CLK); start_a = 1'b1;
        @(posedge CLK);
        for (int n = 1; n <= 40; n++) begin
            @(negedge CLK);
            start_a = 1'b0;
            if (n == 40) CLR = 1'b1;
        end
        @(negedge CLK); CLR = 1'b0;
        check("rst_mid_cnv", cnv_a, 1'b0);
        check("rst_mid_csn", cs_n_a, 1'b1);
        check("rst_mid_sck", sck_a, 1'b0);
        check("rst_mid_busy", busy_a, 1'b0);
        check("rst_mid_valid", valid_a, 1'b0);
        check("rst_mid_data", data_a, '0);
`ifdef ADC_CAP_OVR_EN
        check("rst_mid_ovr", ovr_a, 1'b0);
`endif
        qa.delete();
        for (int n = 0; n < 200; n++) begin
            @(negedge CLK);
            if (valid_a) n_valid++;
        end
        check("rst_mid_no_valid", n_valid, 0);
    endtask

    // Instance B: fast sweep (S=8, CLK_DIV=1, CONV_CYCLES=1), SCK period must be 2 cycles.
    task automatic cap_b(input logic [SB-1:0] word);
        int first_valid, n_valid, n_rise, last_rise, gap_bad, n_cnv;
        logic ps;
        logic [SB-1:0] got;
        first_valid = -1; n_valid = 0; n_rise = 0; last_rise = -1; gap_bad = 0; n_cnv = 0;
        ps = 1'b0; got = '0;
        qb.push_back(word);
        @(negedge CLK); start_b = 1'b1;
        @(posedge CLK);
        for (int n = 1; n <= LAT_B + 10; n++) begin
            @(negedge CLK);
            start_b = 1'b0;
            if (cnv_b) n_cnv++;
            if (sck_b && !ps) begin
                if (last_rise >= 0 && n - last_rise != 2 * DB) gap_bad++;
                last_rise = n;
                n_rise++;
            end
            ps = sck_b;
            if (valid_b) begin
                n_valid++;
                if (first_valid < 0) begin first_valid = n; got = data_b; end
            end
        end
        check("b_valid_cycle", first_valid, LAT_B);
        check("b_valid_count", n_valid, 1);
        check("b_data", got, word);
        check("b_sck_rises", n_rise, SB);
        check("b_sck_period", gap_bad, 0);
        check("b_cnv_cycles", n_cnv, CB);
    endtask

    initial begin
        logic [SA-1:0] w, prev;
        int n_busy;
        CLR = 1'b1; start_a = 1'b0; start_b = 1'b0;
        repeat (3) @(negedge CLK);
        check("reset_cnv", cnv_a, 1'b0);
        check("reset_csn", cs_n_a, 1'b1);
        check("reset_sck", sck_a, 1'b0);
        check("reset_data", data_a, '0);
        check("reset_valid", valid_a, 1'b0);
        check("reset_busy", busy_a, 1'b0);
        check("reset_b_data", data_b, '0);
`ifdef ADC_CAP_OVR_EN
        check("reset_ovr", ovr_a, 1'b0);
`endif
        CLR = 1'b0;

        cap_a(12'hA5C, 12'h000, 1'b0);
        cap_a(12'hFFF, 12'hA5C, 1'b0);
        cap_a(12'h000, 12'hFFF, 1'b0);
        b2b_a(12'h123, 12'h456);

        pulse_clr();
`ifdef ADC_CAP_OVR_EN
        check("ovr_clear_before", ovr_a, 1'b0);
`endif
        w = 12'($urandom);
        cap_a(w, 12'h000, 1'b1);
`ifdef ADC_CAP_OVR_EN
        check("ovr_set", ovr_a, 1'b1);
        repeat (20) @(negedge CLK);
        check("ovr_sticky", ovr_a, 1'b1);
`endif
        reset_mid_a(12'hC3A);

        // CLR and START together: CLR wins and no conversion starts.
        @(negedge CLK); CLR = 1'b1; start_a = 1'b1;
        @(negedge CLK); CLR = 1'b0; start_a = 1'b0;
        n_busy = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge CLK);
            if (busy_a || cnv_a) n_busy++;
        end
        check("clr_start_same", n_busy, 0);

        prev = '0;
        for (int k = 0; k < 4; k++) begin
            w = 12'($urandom);
            repeat ($urandom_range(0, 5)) @(negedge CLK);
            cap_a(w, prev, 1'b0);
            prev = w;
        end

        cap_b(8'h96);
        for (int k = 0; k < 3; k++) cap_b(8'($urandom));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/adc_serial_capture.md
Name: adc_serial_capture

Overview:
- Upstream stage of the 12-bit sample holding register.
- Runs one conversion-and-readout cycle on an external SPI-style ADC: pulses CNV, clocks out S bits MSB-first on SCK/SDO, and presents the parallel word on DATA.
- VALID is a one-cycle strobe that drives the holding register's enable, so each completed sample is latched exactly once.
- Sits between the ADC pins and the Nios-facing sample register.

Parameters:
- S, 12, bits per sample word; must match holding register width.
- CLK_DIV, 2, SCK half-period in CLK cycles; must be ≥1.
- CONV_CYCLES, 80, CLK cycles CNV is held high (ADC conversion time); must be ≥1.

Ports:
- CLK  input  1  system clock; all logic on rising edge.
- CLR  input  1  reset/clear, synchronous, active-high.
- START  input  1  request one conversion; sampled only in IDLE.
- SDO  input  1  ADC serial data out, already synchronous to CLK.
- CNV  output  1  ADC convert strobe.
- CS_N  output  1  ADC chip select, active-low.
- SCK  output  1  ADC serial clock, idles low.
- DATA  output  S  last captured sample, MSB first on wire.
- VALID  output  1  one-cycle strobe; DATA is new in this cycle.
- BUSY  output  1  high whenever state ≠ IDLE.

Behaviour:
- Reset (CLR high at a CLK edge, any state, including mid-shift): next state IDLE.
  - Reset values: CNV=0, CS_N=1, SCK=0, DATA=0, VALID=0, BUSY=0.
  - Bit and cycle counters cleared; partial shift data discarded.
- FSM states: IDLE, CONV, SHIFT, DONE.
- IDLE:
  - All outputs inactive; DATA holds its value.
  - START=1 at edge t → CONV from t+1.
- CONV:
  - CNV=1, CS_N=1, BUSY=1 for exactly CONV_CYCLES cycles (t+1 .. t+CONV_CYCLES), then SHIFT.
- SHIFT:
  - CNV=0, CS_N=0 for exactly 2·CLK_DIV·S cycles.
  - Each bit period is SCK low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - SDO is sampled into the shift register on the CLK edge at which SCK goes 0→1; the first sample is the MSB.
  - After the S-th high phase completes: CS_N=1, SCK=0, go to DONE.
- DONE (1 cycle):
  - DATA ← shift register; VALID=1; BUSY=1.
  - Next state IDLE.
- Latency: START at edge t → VALID high in cycle t+CONV_CYCLES+2·CLK_DIV·S+1 (defaults: t+129).
- START while BUSY: ignored, no queueing.
- START held high continuously: back-to-back conversions separated by one IDLE cycle.
- VALID is never high for two consecutive cycles.
- DATA changes only in DONE or on reset.
- CLR and START asserted in the same cycle: CLR wins, stays IDLE.

Optional Feature:
- Macro: ADC_CAP_OVR_EN.
- Defined:
  - Adds output OVR (1 bit, reset 0).
  - OVR sets sticky when START=1 while BUSY=1, including the DONE cycle.
  - OVR clears only on CLR.
  - Conversion in flight is unaffected.
- Undefined:
  - No OVR port; START while BUSY is silently ignored.

Test Plan:
- Reset mid-operation: START, then CLR at cycle 40 of CONV → next cycle CNV=0, CS_N=1, SCK=0, BUSY=0, VALID=0, DATA=0; no VALID for 200 cycles.
- Single capture: SDO model drives 12'hA5C MSB-first; START pulse at t → VALID only at t+129, DATA=12'hA5C; exactly 12 SCK rising edges; CNV high cycles t+1..t+80.
- Boundary patterns: SDO all-ones, then all-zeros → DATA=12'hFFF, then 12'h000; DATA holds between captures.
- Back-to-back: START held high, SDO gives 12'h123 then 12'h456 → two VALID pulses 130 cycles apart with those values; BUSY low for exactly one cycle between them.
- START while busy: extra START pulses during SHIFT and DONE → no extra conversion; with ADC_CAP_OVR_EN, OVR=1 and sticky until CLR.
- Parameter sweep CLK_DIV=1, CONV_CYCLES=1, S=8: VALID at t+18; SCK period 2 cycles; DATA correct for 8'h96.
